// File: rtl/clk2_pkg.sv
// Shared types and default parameters for the divided-clock monitor.
package clk2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACQ    = 2'd1,
      LOCKED = 2'd2,
      ERR    = 2'd3
   } clk2_state_e;

   localparam int CLK2_DIV_DEF   = 1;
   localparam int CLK2_LOCK_DEF  = 4;
   localparam int CLK2_CNT_W_DEF = 8;

   // Largest value a CNT_W-bit half-period counter can hold before it saturates.
   function automatic int clk2_cnt_max(input int cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

endpackage

// File: rtl/clk2_monitor_if.sv
// Bundle of the divided clock under test and the monitor's strobes and status.
// The monitor side uses the master modport; consumers use the slave modport.
interface clk2_monitor_if
   import clk2_pkg::*;
#(
   parameter int CNT_W = CLK2_CNT_W_DEF
);
   logic             clk2_in;
   logic             rise_pulse;
   logic             fall_pulse;
   logic [CNT_W-1:0] half_period;
   logic             period_valid;
   logic             locked;
   logic             err;

   modport master (
      input  clk2_in,
      output rise_pulse,
      output fall_pulse,
      output half_period,
      output period_valid,
      output locked,
      output err
   );

   modport slave (
      output clk2_in,
      input  rise_pulse,
      input  fall_pulse,
      input  half_period,
      input  period_valid,
      input  locked,
      input  err
   );
endinterface

// File: rtl/edge_detect.sv
// Samples clk2_in on clk and produces registered rise/fall strobes plus a same-cycle edge flag.
// Define CLK2_MONITOR_SYNC_EN to put a two-flop synchronizer in front of the sampler.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic edge_o,
   output logic rise_o,
   output logic fall_o
);

   logic sample_src;

`ifdef CLK2_MONITOR_SYNC_EN
   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], d_in};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign sample_src = sync_q[1];
`else
   // Only safe when d_in is itself a flop clocked by clk.
   assign sample_src = d_in;
`endif

   logic s_q;
   logic s_d;
   logic p_q;
   logic p_d;
   logic rise_q;
   logic rise_d;
   logic fall_q;
   logic fall_d;

   always_comb begin
      s_d    = sample_src;
      p_d    = s_q;
      rise_d = s_q & ~p_q;
      fall_d = ~s_q & p_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q    <= 1'b0;
         p_q    <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         p_q    <= p_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   // The counter in the parent acts on this so its registered outputs line up with the strobes.
   assign edge_o = s_q ^ p_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/clk2_monitor.sv
// Measures each half-period of a divided clock, declares lock after LOCK_CNT matches and flags faults.
// Build option CLK2_MONITOR_SYNC_EN (in edge_detect) adds a synchronizer; values are unchanged.
module clk2_monitor
   import clk2_pkg::*;
#(
   parameter int DIV      = CLK2_DIV_DEF,
   parameter int LOCK_CNT = CLK2_LOCK_DEF,
   parameter int CNT_W    = CLK2_CNT_W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   clk2_monitor_if.master bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(clk2_cnt_max(CNT_W));
   localparam logic [CNT_W-1:0] DIV_C   = CNT_W'(DIV);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);

   logic edge_now;
   logic rise_pulse;
   logic fall_pulse;

   edge_detect u_edge_detect (
      .clk    (clk),
      .rst    (rst),
      .d_in   (bus.clk2_in),
      .edge_o (edge_now),
      .rise_o (rise_pulse),
      .fall_o (fall_pulse)
   );

   clk2_state_e      state_q;
   clk2_state_e      state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] half_period_q;
   logic [CNT_W-1:0] half_period_d;
   logic             period_valid_q;
   logic             period_valid_d;
   logic [3:0]       good_cnt_q;
   logic [3:0]       good_cnt_d;

   logic saturated;
   logic meas_good;
   logic meas_bad;

   // Counter and measurement register.
   always_comb begin
      cnt_d          = cnt_q;
      half_period_d  = half_period_q;
      period_valid_d = 1'b0;

      if (edge_now) begin
         cnt_d = CNT_ONE;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_ONE;
      end

      // The interval ending at the first edge is partial, so it is not reported.
      if (edge_now && (state_q != IDLE)) begin
         half_period_d  = cnt_q;
         period_valid_d = 1'b1;
      end
   end

   // The FSM judges the registered measurement, so locked/err trail period_valid by one cycle.
   assign saturated = (cnt_q == CNT_MAX);
   assign meas_good = period_valid_q && (half_period_q == DIV_C);
   assign meas_bad  = period_valid_q && (half_period_q != DIV_C);

   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (edge_now) begin
               state_d = ACQ;
            end
         end
         ACQ: begin
            if (saturated) begin
               state_d = ERR;
            end else if (meas_good) begin
               good_cnt_d = good_cnt_q + 4'd1;
               if ((good_cnt_q + 4'd1) == LOCK_C) begin
                  state_d = LOCKED;
               end
            end else if (meas_bad) begin
               good_cnt_d = 4'd0;
            end
         end
         LOCKED: begin
            if (saturated || meas_bad) begin
               state_d = ERR;
            end
         end
         ERR: begin
            state_d = ERR;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         half_period_q  <= '0;
         period_valid_q <= 1'b0;
         good_cnt_q     <= 4'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         half_period_q  <= half_period_d;
         period_valid_q <= period_valid_d;
         good_cnt_q     <= good_cnt_d;
      end
   end

   assign bus.rise_pulse   = rise_pulse;
   assign bus.fall_pulse   = fall_pulse;
   assign bus.half_period  = half_period_q;
   assign bus.period_valid = period_valid_q;
   assign bus.locked       = (state_q == LOCKED);
   assign bus.err          = (state_q == ERR);

endmodule

// File: tb/tb_clk2_monitor.sv
// Directed bench for clk2_monitor: two instances (DIV=1 and DIV=3) share one clk2_in stimulus.
module tb_clk2_monitor;

`ifdef CLK2_MONITOR_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif
   localparam int DRAIN = 10;

   typedef struct {
      int n;
      int hp;
      int lk;
      int er;
   } vec_t;

   typedef struct {
      int hp;
      int lk;
      int er;
   } rec_t;

   logic clk;
   logic rst;
   logic clk2_in;

   int n_tests = 0;
   int n_fail  = 0;

   clk2_monitor_if #(.CNT_W(8)) if1 ();
   clk2_monitor_if #(.CNT_W(8)) if3 ();

   assign if1.clk2_in = clk2_in;
   assign if3.clk2_in = clk2_in;

   clk2_monitor #(.DIV(1), .LOCK_CNT(4), .CNT_W(8)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   clk2_monitor #(.DIV(3), .LOCK_CNT(4), .CNT_W(8)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (if3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Per-measurement log: half_period at the strobe, locked/err one cycle later.
   rec_t       q1[$];
   rec_t       q3[$];
   logic       pv1_prev = 1'b0;
   logic       pv3_prev = 1'b0;
   logic [7:0] hp1_prev = 8'd0;
   logic [7:0] hp3_prev = 8'd0;
   int         rise1_cnt = 0;
   int         fall1_cnt = 0;
   int         both1_cnt = 0;

   always @(negedge clk) begin
      if (pv1_prev) q1.push_back('{int'(hp1_prev), int'(if1.locked), int'(if1.err)});
      if (pv3_prev) q3.push_back('{int'(hp3_prev), int'(if3.locked), int'(if3.err)});
      pv1_prev <= if1.period_valid;
      hp1_prev <= if1.half_period;
      pv3_prev <= if3.period_valid;
      hp3_prev <= if3.half_period;
      if (if1.rise_pulse) rise1_cnt <= rise1_cnt + 1;
      if (if1.fall_pulse) fall1_cnt <= fall1_cnt + 1;
      if (if1.rise_pulse && if1.fall_pulse) both1_cnt <= both1_cnt + 1;
   end

   vec_t vecs[20];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      clk2_in = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // One edge, then the new level is held for n sampled cycles.
   task automatic half(input int n);
      @(negedge clk);
      clk2_in = ~clk2_in;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic run_phase(input int first, input int count, input int sel);
      int   size;
      rec_t r;
      if (sel == 1) q1.delete();
      else          q3.delete();
      for (int i = first; i < first + count; i++) half(vecs[i].n);
      @(negedge clk);
      clk2_in = ~clk2_in;
      repeat (DRAIN) @(negedge clk);
      size = (sel == 1) ? q1.size() : q3.size();
      check("meas_count", size, count);
      for (int j = 0; j < count && j < size; j++) begin
         if (sel == 1) r = q1[j];
         else          r = q3[j];
         $display("[TB] dut%0d meas %0d: half_period=%0d locked=%0d err=%0d", sel, j, r.hp, r.lk, r.er);
         check("half_period", r.hp, vecs[first + j].hp);
         check("locked_next", r.lk, vecs[first + j].lk);
         check("err_next", r.er, vecs[first + j].er);
      end
   endtask

   initial begin
      int lat;
      int pv_at;
      int fall_at;
      int prev_lk;
      int lk_before;
      int r0;
      int f0;

      // DIV=1: six good half-periods, lock after the 4th.
      vecs[0]  = '{1, 1, 0, 0};
      vecs[1]  = '{1, 1, 0, 0};
      vecs[2]  = '{1, 1, 0, 0};
      vecs[3]  = '{1, 1, 1, 0};
      vecs[4]  = '{1, 1, 1, 0};
      vecs[5]  = '{1, 1, 1, 0};
      // DIV=3: lock after 4, then a 2-cycle half-period faults; ERR is absorbing.
      vecs[6]  = '{3, 3, 0, 0};
      vecs[7]  = '{3, 3, 0, 0};
      vecs[8]  = '{3, 3, 0, 0};
      vecs[9]  = '{3, 3, 1, 0};
      vecs[10] = '{3, 3, 1, 0};
      vecs[11] = '{2, 2, 0, 1};
      vecs[12] = '{3, 3, 0, 1};
      // DIV=1: good, good, bad, then four good before lock.
      vecs[13] = '{1, 1, 0, 0};
      vecs[14] = '{1, 1, 0, 0};
      vecs[15] = '{2, 2, 0, 0};
      vecs[16] = '{1, 1, 0, 0};
      vecs[17] = '{1, 1, 0, 0};
      vecs[18] = '{1, 1, 0, 0};
      vecs[19] = '{1, 1, 1, 0};

      rst     = 1'b1;
      clk2_in = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_rise", int'(if1.rise_pulse), 0);
      check("rst_fall", int'(if1.fall_pulse), 0);
      check("rst_pv", int'(if1.period_valid), 0);
      check("rst_hp", int'(if1.half_period), 0);
      check("rst_locked", int'(if1.locked), 0);
      check("rst_err", int'(if1.err), 0);
      check("rst_locked3", int'(if3.locked), 0);
      check("rst_err3", int'(if3.err), 0);

      // First edge: latency and no period_valid.
      rst = 1'b0;
      repeat (3) @(negedge clk);
      clk2_in = 1'b1;
      lat = 0; pv_at = 1; fall_at = 1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (if1.rise_pulse) begin
            lat = i; pv_at = int'(if1.period_valid); fall_at = int'(if1.fall_pulse);
            break;
         end
      end
      $display("[TB] first edge: rise after %0d cycles", lat);
      check("first_edge_latency", lat, LAT);
      check("first_edge_no_pv", pv_at, 0);
      check("first_edge_no_fall", fall_at, 0);
      check("first_edge_hp", int'(if1.half_period), 0);

      do_reset();
      r0 = rise1_cnt;
      f0 = fall1_cnt;
      run_phase(0, 6, 1);
      check("rise_count", rise1_cnt - r0, 4);
      check("fall_count", fall1_cnt - f0, 3);
      check("rise_fall_overlap", both1_cnt, 0);

      // One-cycle reset while locked, clk2_in high across the release.
      check("locked_before_rst", int'(if1.locked), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_rise", int'(if1.rise_pulse), 0);
      check("midrst_fall", int'(if1.fall_pulse), 0);
      check("midrst_pv", int'(if1.period_valid), 0);
      check("midrst_hp", int'(if1.half_period), 0);
      check("midrst_locked", int'(if1.locked), 0);
      check("midrst_err", int'(if1.err), 0);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (if1.rise_pulse) begin
            lat = i;
            break;
         end
      end
      $display("[TB] release with clk2_in high: rise after %0d cycles", lat);
      check("release_rise_latency", lat, LAT);
      repeat (6) half(1);
      repeat (DRAIN) @(negedge clk);
      $display("[TB] relock: locked=%0d err=%0d", if1.locked, if1.err);
      check("relock_locked", int'(if1.locked), 1);
      check("relock_err", int'(if1.err), 0);

      do_reset();
      run_phase(6, 7, 3);
      check("err_absorbing", int'(if3.err), 1);
      check("err_not_locked", int'(if3.locked), 0);

      do_reset();
      run_phase(13, 7, 1);

      // Lock, then stop the clock: err 255 cycles after the last strobe.
      do_reset();
      repeat (5) half(1);
      @(negedge clk);
      clk2_in   = ~clk2_in;
      lat       = 0;
      prev_lk   = 0;
      lk_before = 0;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (if1.err) begin
            lat = i; lk_before = prev_lk;
            break;
         end
         prev_lk = int'(if1.locked);
      end
      $display("[TB] stopped clock: err after %0d cycles", lat);
      check("sat_err_delay", lat, LAT + 255);
      check("sat_locked_before", lk_before, 1);
      q1.delete();
      @(negedge clk);
      clk2_in = ~clk2_in;
      repeat (DRAIN) @(negedge clk);
      check("sat_meas_count", q1.size(), 1);
      if (q1.size() > 0) begin
         $display("[TB] dut1 post-stall meas: half_period=%0d locked=%0d err=%0d", q1[0].hp, q1[0].lk, q1[0].er);
         check("sat_half_period", q1[0].hp, 255);
         check("sat_err_next", q1[0].er, 1);
         check("sat_locked_next", q1[0].lk, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
